// File: rtl/lemming_arb_pkg.sv
// lemming_arb_pkg: shared state encoding and default sizing for the bridge arbiter.
// Revision 1.0
`default_nettype none

package lemming_arb_pkg;

  localparam int DEF_N         = 4;
  localparam int DEF_CROSS_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CROSS = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/lemming_bridge_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting just above last_owner.
// Revision 1.0
`default_nettype none

module rr_pick
  import lemming_arb_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_owner,
  output logic                 valid,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);

  // Scan from lowest to highest priority so the last hit is the winner;
  // offset N lands on last_owner itself, which therefore ranks last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int k = N; k >= 1; k--) begin
      if (req[IW'((int'(last_owner) + k) % N)]) begin
        valid = 1'b1;
        index = IW'((int'(last_owner) + k) % N);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lemming_bridge_arbiter.sv
// lemming_bridge_arbiter: round-robin owner of a single-lane bridge with hold timeout.
// Revision 1.0
`default_nettype none

module lemming_bridge_arbiter
  import lemming_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int CROSS_MAX = DEF_CROSS_MAX
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic                 busy,
  output logic                 timeout,
  output logic [$clog2(N)-1:0] owner
);

  localparam int         IW    = $clog2(N);
  localparam logic [7:0] LIMIT = 8'(CROSS_MAX - 1);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  rr_pick #(.N(N)) u_rr_pick (
    .req        (req),
    .last_owner (last_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      owner_q   <= '0;
      last_q    <= IW'(N - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d           = CROSS;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          busy_d            = 1'b1;
          owner_d           = pick_idx;
          last_d            = pick_idx;
          cnt_d             = '0;
        end
      end
      CROSS: begin
        if (done[owner_q] || !req[owner_q] || (cnt_q == LIMIT)) begin
          state_d   = GAP;
          grant_d   = '0;
          busy_d    = 1'b0;
          owner_d   = '0;
          cnt_d     = '0;
          // Only a pure limit expiry is a timeout; done or abandon take precedence.
          timeout_d = req[owner_q] && !done[owner_q];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign owner   = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_lemming_bridge_arbiter.sv
// tb_lemming_bridge_arbiter: directed scenario bench for the bridge arbiter (N=4, CROSS_MAX=8).
// Revision 1.0
`default_nettype none

module tb_lemming_bridge_arbiter;

  logic       clk = 1'b0;
  logic       areset_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;
  logic [1:0] owner;

  int checks = 0;
  int errors = 0;

  lemming_bridge_arbiter #(.N(4), .CROSS_MAX(8)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .busy     (busy),
    .timeout  (timeout),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    req      = 4'b0000;
    done     = 4'b0000;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: grant=%b busy=%b timeout=%b owner=%0d, required 0000/0/0/0",
               grant, busy, timeout, owner);
    end
  endtask

  // Reset release with 0101; owner 0 holds 4 cycles, done on the 4th.
  task automatic test_release_and_done();
    req = 4'b0101;
    tick();
    areset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0001 || busy !== 1'b1 || owner !== 2'd0) begin
        errors++;
        $display("FAIL first_grant cyc%0d: grant=%b busy=%b owner=%0d, required 0001/1/0",
                 i, grant, busy, owner);
      end
      if (i == 3) done = 4'b0001;
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      done = 4'b0000;
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL gap_after_done %0d: grant=%b busy=%b timeout=%b, required 0000/0/0",
                 i, grant, busy, timeout);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL second_grant: grant=%b owner=%0d, required 0100/2", grant, owner);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] order [5];
    logic [3:0] exp_g;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    areset_n = 1'b0;
    tick();
    req = 4'b1111;
    areset_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << order[n];
      tick();
      checks++;
      if (grant !== exp_g || owner !== order[n] || timeout !== 1'b0) begin
        errors++;
        $display("FAIL rr_grant %0d: grant=%b owner=%0d timeout=%b, required %b/%0d/0",
                 n, grant, owner, timeout, exp_g, order[n]);
      end
      tick();
      checks++;
      if (grant !== exp_g) begin
        errors++;
        $display("FAIL rr_hold %0d: grant=%b, required %b", n, grant, exp_g);
      end
      done = exp_g;
      tick();
      done = 4'b0000;
      checks++;
      if (grant !== 4'b0000 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL rr_release %0d: grant=%b timeout=%b, required 0000/0", n, grant, timeout);
      end
      tick();
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    req = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0010 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_hold cyc%0d: grant=%b timeout=%b, required 0010/0", i, grant, timeout);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: grant=%b timeout=%b busy=%b, required 0000/1/0", grant, timeout, busy);
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse_end: grant=%b timeout=%b, required 0000/0", grant, timeout);
    end
    tick();
    checks++;
    if (grant !== 4'b0010 || owner !== 2'd1) begin
      errors++;
      $display("FAIL to_regrant: grant=%b owner=%0d, required 0010/1", grant, owner);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  // last_owner is 1 here, so 1101 picks 2; after abandon the search starts at 3.
  task automatic test_abandon();
    req = 4'b1101;
    tick();
    checks++;
    if (grant !== 4'b0100) begin
      errors++;
      $display("FAIL ab_grant: grant=%b, required 0100", grant);
    end
    tick();
    req = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0000 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL ab_release %0d: grant=%b timeout=%b, required 0000/0", i, grant, timeout);
      end
    end
    tick();
    checks++;
    if (grant !== 4'b1000 || owner !== 2'd3) begin
      errors++;
      $display("FAIL ab_next: grant=%b owner=%0d, required 1000/3", grant, owner);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_done_vs_limit();
    req = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (grant !== 4'b0010 || owner !== 2'd1) begin
        errors++;
        $display("FAIL dl_hold cyc%0d: grant=%b owner=%0d, required 0010/1", i, grant, owner);
      end
      done = (i == 7) ? 4'b0010 : 4'b1000;
    end
    tick();
    done = 4'b0000;
    req  = 4'b0000;
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL dl_coincide: grant=%b timeout=%b, required 0000/0", grant, timeout);
    end
    tick();
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL dl_no_late_pulse: timeout=%b, required 0", timeout);
    end
  endtask

  task automatic test_reset_mid_cross();
    req = 4'b0100;
    tick();
    tick();
    checks++;
    if (grant !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL rm_grant: grant=%b owner=%0d, required 0100/2", grant, owner);
    end
    #2;
    areset_n = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL rm_async: grant=%b busy=%b timeout=%b owner=%0d, required 0000/0/0/0",
               grant, busy, timeout, owner);
    end
    req = 4'b1111;
    tick();
    areset_n = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0001 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL rm_restart: grant=%b timeout=%b, required 0001/0", grant, timeout);
    end
  endtask

  initial begin
    test_reset();
    test_release_and_done();
    test_round_robin();
    test_timeout();
    test_abandon();
    test_done_vs_limit();
    test_reset_mid_cross();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
